// File: rtl/d_regfile_sb_pkg.sv
// Shared constants for the D-stage register file with scoreboard.
package d_regfile_sb_pkg;

   // Register that always reads as zero and ignores writes and issues.
   localparam int GRF_ZERO_REG = 0;

   // Default geometry.
   localparam int DEF_DATA_W = 32;
   localparam int DEF_NREG   = 32;
   localparam int DEF_NRD    = 2;

   // Write-back port priority: the low port is applied first, the high port
   // last, so the high port wins a same-address conflict in storage and bypass.
   localparam int WR_LO_PORT = 0;
   localparam int WR_HI_PORT = 1;

endpackage

// File: rtl/d_regfile_sb_if.sv
// Bus bundle between the D stage (master) and the register file (slave).
interface d_regfile_sb_if
   import d_regfile_sb_pkg::*;
#(
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  NREG   = DEF_NREG,
   parameter int  NRD    = DEF_NRD,
   localparam int AW     = $clog2(NREG)
) ();

   // Read ports: port k uses rd_addr[k*AW +: AW] and rd_data[k*DATA_W +: DATA_W].
   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_ready;

   // Two write-back ports, port p at [p*AW +: AW] / [p*DATA_W +: DATA_W].
   logic [1:0]            wr_en;
   logic [2*AW-1:0]       wr_addr;
   logic [2*DATA_W-1:0]   wr_data;

   // Issue: marks iss_addr as having an in-flight producer from the next cycle.
   logic                  iss_en;
   logic [AW-1:0]         iss_addr;

   // Registered scoreboard view.
   logic [NREG-1:0]       pend_vec;
   logic [AW:0]           pend_cnt;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_ready, pend_vec, pend_cnt
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_ready, pend_vec, pend_cnt
   );

endinterface

// File: rtl/d_regfile_sb_bypass.sv
// One read port: zero register, write-back bypass, array data and ready mux.
module d_regfile_sb_bypass
   import d_regfile_sb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int AW     = 5
) (
   input  logic [AW-1:0]       rd_addr_i,
   input  logic [1:0]          wr_en_i,
   input  logic [2*AW-1:0]     wr_addr_i,
   input  logic [2*DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0]   arr_data_i,
   input  logic                pend_i,
   output logic [DATA_W-1:0]   rd_data_o,
   output logic                rd_ready_o
);

   logic hit_lo;
   logic hit_hi;

   assign hit_lo = wr_en_i[WR_LO_PORT] && (wr_addr_i[WR_LO_PORT*AW +: AW] == rd_addr_i);
   assign hit_hi = wr_en_i[WR_HI_PORT] && (wr_addr_i[WR_HI_PORT*AW +: AW] == rd_addr_i);

   // Zero register first, then a same-cycle write-back (high port first), else storage.
   always_comb begin
      rd_data_o  = arr_data_i;
      rd_ready_o = !pend_i;
      if (rd_addr_i == AW'(GRF_ZERO_REG)) begin
         rd_data_o  = '0;
         rd_ready_o = 1'b1;
      end else if (hit_hi) begin
         rd_data_o  = wr_data_i[WR_HI_PORT*DATA_W +: DATA_W];
         rd_ready_o = 1'b1;
      end else if (hit_lo) begin
         rd_data_o  = wr_data_i[WR_LO_PORT*DATA_W +: DATA_W];
         rd_ready_o = 1'b1;
      end
   end

endmodule

// File: rtl/d_regfile_sb.sv
// D-stage register file: storage, per-register pending scoreboard, pending count.
module d_regfile_sb
   import d_regfile_sb_pkg::*;
#(
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  NREG   = DEF_NREG,
   parameter int  NRD    = DEF_NRD,
   localparam int AW     = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           reset,
   d_regfile_sb_if.slave  bus
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   pend_q;
   logic [NREG-1:0]   pend_d;
   logic [AW:0]       cnt_q;
   logic [AW:0]       cnt_d;

   logic [AW-1:0]     wa [2];
   logic [DATA_W-1:0] wd [2];
   logic [1:0]        wv;

   // Split the write-back bus; a write to the zero register never lands.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         wa[p] = bus.wr_addr[p*AW +: AW];
         wd[p] = bus.wr_data[p*DATA_W +: DATA_W];
         wv[p] = bus.wr_en[p] && (wa[p] != AW'(GRF_ZERO_REG));
      end
   end

   // Storage next state: low port first so the high port overwrites on conflict.
   always_comb begin
      regs_d = regs_q;
      if (wv[WR_LO_PORT]) regs_d[wa[WR_LO_PORT]] = wd[WR_LO_PORT];
      if (wv[WR_HI_PORT]) regs_d[wa[WR_HI_PORT]] = wd[WR_HI_PORT];
   end

   // Scoreboard next state: an issue beats a same-cycle write-back to the same register.
   always_comb begin
      pend_d = '0;
      for (int r = 1; r < NREG; r++) begin
         pend_d[r] = pend_q[r];
         if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
            pend_d[r] = 1'b1;
         end else if ((wv[0] && (wa[0] == AW'(r))) || (wv[1] && (wa[1] == AW'(r)))) begin
            pend_d[r] = 1'b0;
         end
      end
   end

   // Pending count tracks the population of the next pending vector.
   always_comb begin
      cnt_d = '0;
      for (int r = 0; r < NREG; r++) begin
         cnt_d = cnt_d + {{AW{1'b0}}, pend_d[r]};
      end
   end

   // State registers; reset discards any write or issue of the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.pend_vec = pend_q;
   assign bus.pend_cnt = cnt_q;

   // One bypass mux per read port.
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = bus.rd_addr[k*AW +: AW];

      d_regfile_sb_bypass #(
         .DATA_W (DATA_W),
         .AW     (AW)
      ) u_bypass (
         .rd_addr_i  (ra),
         .wr_en_i    (bus.wr_en),
         .wr_addr_i  (bus.wr_addr),
         .wr_data_i  (bus.wr_data),
         .arr_data_i (regs_q[ra]),
         .pend_i     (pend_q[ra]),
         .rd_data_o  (bus.rd_data[k*DATA_W +: DATA_W]),
         .rd_ready_o (bus.rd_ready[k])
      );
   end

endmodule

// File: tb/tb_d_regfile_sb.sv
// Testbench for d_regfile_sb: directed vector table, random run against a
// rule-level model, async reset corners, and a 3-port 16x16 build.
module tb_d_regfile_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int DW3 = 16;
  localparam int NR3 = 16;
  localparam int NP3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  d_regfile_sb_if #(.DATA_W(DW),  .NREG(NR),  .NRD(2))   bus2 ();
  d_regfile_sb_if #(.DATA_W(DW3), .NREG(NR3), .NRD(NP3)) bus3 ();

  d_regfile_sb #(.DATA_W(DW), .NREG(NR), .NRD(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  d_regfile_sb #(.DATA_W(DW3), .NREG(NR3), .NRD(NP3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // current stimulus for the 32x32 build
  logic [1:0]  c_wen;
  logic [4:0]  c_wa [2];
  logic [31:0] c_wd [2];
  logic        c_iss;
  logic [4:0]  c_ia;
  logic [4:0]  c_ra [2];

  // reference model state
  logic [31:0]   m_regs [NR];
  logic [NR-1:0] m_pend;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic        er0;
    logic [31:0] ed1;
    logic        er1;
    logic [31:0] epend;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vt [12];

  function automatic vec_t mk(int wen, int wa0, int wd0, int wa1, int wd1, int iss, int ia,
                              int ra0, int ra1, int ed0, int er0, int ed1, int er1,
                              int epend, int ecnt);
    vec_t v;
    v.wen = 2'(wen);   v.wa0 = 5'(wa0); v.wd0 = 32'(wd0); v.wa1 = 5'(wa1); v.wd1 = 32'(wd1);
    v.iss = 1'(iss);   v.ia  = 5'(ia);  v.ra0 = 5'(ra0);  v.ra1 = 5'(ra1);
    v.ed0 = 32'(ed0);  v.er0 = 1'(er0); v.ed1 = 32'(ed1); v.er1 = 1'(er1);
    v.epend = 32'(epend); v.ecnt = 6'(ecnt);
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply2();
    bus2.wr_en    = c_wen;
    bus2.wr_addr  = {c_wa[1], c_wa[0]};
    bus2.wr_data  = {c_wd[1], c_wd[0]};
    bus2.iss_en   = c_iss;
    bus2.iss_addr = c_ia;
    bus2.rd_addr  = {c_ra[1], c_ra[0]};
  endtask

  task automatic idle2();
    c_wen = 2'b00; c_wa[0] = '0; c_wa[1] = '0; c_wd[0] = '0; c_wd[1] = '0;
    c_iss = 1'b0;  c_ia = '0;
    apply2();
  endtask

  task automatic idle3();
    bus3.wr_en = '0; bus3.wr_addr = '0; bus3.wr_data = '0;
    bus3.iss_en = 1'b0; bus3.iss_addr = '0; bus3.rd_addr = '0;
  endtask

  // ---------------- reference model ----------------
  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic r);
    if (a == 5'd0) begin
      d = '0; r = 1'b1;
    end else if (c_wen[1] && c_wa[1] == a) begin
      d = c_wd[1]; r = 1'b1;
    end else if (c_wen[0] && c_wa[0] == a) begin
      d = c_wd[0]; r = 1'b1;
    end else begin
      d = m_regs[a]; r = !m_pend[a];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  // Applies one clock edge of the current stimulus to the model.
  task automatic model_edge();
    logic [NR-1:0] nxt;
    logic          wb;
    if (reset) begin
      model_reset();
      return;
    end
    nxt = m_pend;
    for (int r = 1; r < NR; r++) begin
      wb = (c_wen[0] && c_wa[0] == 5'(r)) || (c_wen[1] && c_wa[1] == 5'(r));
      if (c_iss && c_ia == 5'(r)) nxt[r] = 1'b1;
      else if (wb)                nxt[r] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (c_wen[p] && c_wa[p] != 5'd0) m_regs[c_wa[p]] = c_wd[p];
    end
    m_pend = nxt;
  endtask

  function automatic logic [5:0] model_cnt();
    int s = 0;
    for (int r = 0; r < NR; r++) s += int'(m_pend[r]);
    return 6'(s);
  endfunction

  // One model-checked cycle: inputs must already be in c_*.
  task automatic model_cycle(input string tag);
    logic [31:0] d;
    logic        r;
    apply2();
    #1;
    for (int k = 0; k < 2; k++) begin
      model_read(c_ra[k], d, r);
      chk($sformatf("%s rd_data%0d", tag, k), 64'(bus2.rd_data[k*DW +: DW]), 64'(d));
      chk($sformatf("%s rd_ready%0d", tag, k), 64'(bus2.rd_ready[k]), 64'(r));
    end
    model_edge();
    @(posedge clk);
    #1;
    chk($sformatf("%s pend_vec", tag), 64'(bus2.pend_vec), 64'(m_pend));
    chk($sformatf("%s pend_cnt", tag), 64'(bus2.pend_cnt), 64'(model_cnt()));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // reset state, no clock edge yet
    reset = 1'b1;
    c_ra[0] = 5'd5; c_ra[1] = 5'd0;
    idle2();
    idle3();
    model_reset();
    #2;
    chk("reset pend_cnt", 64'(bus2.pend_cnt), 64'd0);
    chk("reset pend_vec", 64'(bus2.pend_vec), 64'd0);
    chk("reset rd_data0", 64'(bus2.rd_data[0 +: DW]), 64'd0);
    chk("reset rd_ready0", 64'(bus2.rd_ready[0]), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // directed vector table, cumulative from reset
    vt[0]  = mk(1, 5, 'h1234, 0, 0,       0, 0, 5, 0, 'h1234, 1, 0,      1, 0,     0);
    vt[1]  = mk(0, 0, 0,      0, 0,       0, 0, 5, 7, 'h1234, 1, 0,      1, 0,     0);
    vt[2]  = mk(3, 7, 'hAAAA, 7, 'hBBBB,  0, 0, 7, 5, 'hBBBB, 1, 'h1234, 1, 0,     0);
    vt[3]  = mk(0, 0, 0,      0, 0,       1, 3, 7, 3, 'hBBBB, 1, 0,      1, 'h8,   1);
    vt[4]  = mk(0, 0, 0,      0, 0,       0, 0, 3, 7, 0,      0, 'hBBBB, 1, 'h8,   1);
    vt[5]  = mk(1, 3, 'h55,   0, 0,       0, 0, 3, 3, 'h55,   1, 'h55,   1, 0,     0);
    vt[6]  = mk(0, 0, 0,      0, 0,       0, 0, 3, 5, 'h55,   1, 'h1234, 1, 0,     0);
    vt[7]  = mk(2, 0, 0,      9, 'h99,    1, 9, 9, 0, 'h99,   1, 0,      1, 'h200, 1);
    vt[8]  = mk(0, 0, 0,      0, 0,       1, 0, 9, 9, 'h99,   0, 'h99,   0, 'h200, 1);
    vt[9]  = mk(1, 0, 'hFFFF, 0, 0,       1, 9, 0, 9, 0,      1, 'h99,   0, 'h200, 1);
    vt[10] = mk(0, 0, 0,      0, 0,       0, 0, 0, 9, 0,      1, 'h99,   0, 'h200, 1);
    vt[11] = mk(3, 9, 'h77,   9, 'h88,    0, 0, 9, 5, 'h88,   1, 'h1234, 1, 0,     0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      c_wen = vt[i].wen; c_wa[0] = vt[i].wa0; c_wd[0] = vt[i].wd0;
      c_wa[1] = vt[i].wa1; c_wd[1] = vt[i].wd1;
      c_iss = vt[i].iss; c_ia = vt[i].ia; c_ra[0] = vt[i].ra0; c_ra[1] = vt[i].ra1;
      apply2();
      #1;
      chk($sformatf("vec%0d rd_data0", i), 64'(bus2.rd_data[0 +: DW]), 64'(vt[i].ed0));
      chk($sformatf("vec%0d rd_ready0", i), 64'(bus2.rd_ready[0]), 64'(vt[i].er0));
      chk($sformatf("vec%0d rd_data1", i), 64'(bus2.rd_data[DW +: DW]), 64'(vt[i].ed1));
      chk($sformatf("vec%0d rd_ready1", i), 64'(bus2.rd_ready[1]), 64'(vt[i].er1));
      model_edge();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pend_vec", i), 64'(bus2.pend_vec), 64'(vt[i].epend));
      chk($sformatf("vec%0d pend_cnt", i), 64'(bus2.pend_cnt), 64'(vt[i].ecnt));
    end

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      c_wen   = 2'($urandom_range(0, 3));
      c_wa[0] = 5'($urandom_range(0, 15));
      c_wa[1] = ($urandom_range(0, 3) == 0) ? c_wa[0] : 5'($urandom_range(0, 15));
      c_wd[0] = $urandom();
      c_wd[1] = $urandom();
      c_iss   = ($urandom_range(0, 2) == 0);
      c_ia    = ($urandom_range(0, 4) == 0) ? c_wa[0] : 5'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0:       c_ra[k] = c_wa[0];
          1:       c_ra[k] = c_wa[1];
          default: c_ra[k] = 5'($urandom_range(0, 15));
        endcase
      end
      model_cycle($sformatf("rnd%0d", n));
    end

    // clear the scoreboard, then plant a known value in reg 10
    @(negedge clk);
    c_wen = 2'b00; c_iss = 1'b0; c_ra[0] = 5'd10; c_ra[1] = 5'd0;
    for (int r = 1; r < NR; r += 2) begin
      @(negedge clk);
      c_wen = 2'b11; c_wa[0] = 5'(r); c_wa[1] = 5'(r + 1 < NR ? r + 1 : r);
      c_wd[0] = 32'(r); c_wd[1] = 32'(r + 1); c_iss = 1'b0;
      model_cycle($sformatf("clr%0d", r));
    end
    @(negedge clk);
    c_wen = 2'b01; c_wa[0] = 5'd10; c_wd[0] = 32'hCAFE; c_iss = 1'b1; c_ia = 5'd12;
    c_ra[0] = 5'd11; c_ra[1] = 5'd12;
    model_cycle("plant");
    @(negedge clk);
    idle2();
    c_ra[0] = 5'd10; c_ra[1] = 5'd12;
    apply2();
    #1;
    chk("plant rd_data0", 64'(bus2.rd_data[0 +: DW]), 64'h0000CAFE);
    chk("plant rd_ready1", 64'(bus2.rd_ready[1]), 64'd0);

    // mid-cycle async reset with a write and an issue in flight
    c_wen = 2'b11; c_wa[0] = 5'd4; c_wa[1] = 5'd6; c_wd[0] = 32'h4444; c_wd[1] = 32'h6666;
    c_iss = 1'b1; c_ia = 5'd13;
    apply2();
    #1;
    reset = 1'b1;
    #1;
    chk("areset rd_data0", 64'(bus2.rd_data[0 +: DW]), 64'd0);
    chk("areset rd_ready1", 64'(bus2.rd_ready[1]), 64'd1);
    chk("areset pend_cnt", 64'(bus2.pend_cnt), 64'd0);
    chk("areset pend_vec", 64'(bus2.pend_vec), 64'd0);
    model_edge();
    @(negedge clk);
    reset = 1'b0;
    idle2();
    c_ra[0] = 5'd4; c_ra[1] = 5'd6;
    apply2();
    #1;
    chk("post-reset reg4", 64'(bus2.rd_data[0 +: DW]), 64'd0);
    chk("post-reset reg6", 64'(bus2.rd_data[DW +: DW]), 64'd0);
    @(posedge clk);
    #1;
    chk("post-reset pend_vec", 64'(bus2.pend_vec), 64'd0);
    chk("post-reset pend_cnt", 64'(bus2.pend_cnt), 64'd0);

    // 3-port 16x16 build: fill the scoreboard
    for (int k = 1; k < NR3; k++) begin
      @(negedge clk);
      bus3.iss_en = 1'b1; bus3.iss_addr = 4'(k);
      @(posedge clk);
      #1;
      chk($sformatf("nrd3 pend_cnt after issue %0d", k), 64'(bus3.pend_cnt), 64'(k));
    end
    @(negedge clk);
    bus3.iss_en = 1'b1; bus3.iss_addr = 4'd0;
    bus3.rd_addr = '0;
    #1;
    for (int k = 0; k < NP3; k++) begin
      chk($sformatf("nrd3 zero rd_data%0d", k), 64'(bus3.rd_data[k*DW3 +: DW3]), 64'd0);
      chk($sformatf("nrd3 zero rd_ready%0d", k), 64'(bus3.rd_ready[k]), 64'd1);
    end
    @(posedge clk);
    #1;
    chk("nrd3 issue-0 pend_cnt", 64'(bus3.pend_cnt), 64'd15);
    chk("nrd3 pend_vec", 64'(bus3.pend_vec), 64'hFFFE);
    @(negedge clk);
    bus3.iss_en = 1'b0;
    bus3.rd_addr = {4'd15, 4'd0, 4'd5};
    #1;
    chk("nrd3 pending rd_ready0", 64'(bus3.rd_ready[0]), 64'd0);
    chk("nrd3 zero mid rd_ready1", 64'(bus3.rd_ready[1]), 64'd1);
    chk("nrd3 pending rd_ready2", 64'(bus3.rd_ready[2]), 64'd0);
    idle3();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
